// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters
// using a round-robin grant. At most one operation is in flight.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [1:0]        request valid, bit i = requester i
//   req_ready  [1:0]        request accepted when valid & ready
//   req_op     [3:0]        {op1,op0}: 00 AND, 01 OR, 10 XOR, 11 NOR
//   req_a      [2*WIDTH-1:0] {a1,a0}
//   req_b      [2*WIDTH-1:0] {b1,b0}
//   rsp_valid  [1:0]        result valid for requester i
//   rsp_ready  [1:0]        requester i takes the result
//   rsp_data   [WIDTH-1:0]  shared result bus
//   busy                    high whenever not idle
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic             gnt;
  logic             gnt_any;
  logic [WIDTH-1:0] result;

  // Contention goes to prio; otherwise the lone valid requester wins.
  always_comb begin
    gnt_any = |req_valid;
    gnt     = (&req_valid) ? prio_q : req_valid[1];
  end

  always_comb begin
    unique case (op_q)
      2'b00:   result = a_q & b_q;
      2'b01:   result = a_q | b_q;
      2'b10:   result = a_q ^ b_q;
      default: result = ~(a_q | b_q);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          req_ready[gnt] = 1'b1;
          owner_d        = gnt;
          op_d           = gnt ? req_op[3:2] : req_op[1:0];
          a_d            = gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d            = gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          state_d        = StExec;
        end
      end
      StExec: begin
        data_d      = result;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = StResp;
      end
      StResp: begin
        // Only the owner's ready completes the transfer.
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = 2'b00;
          prio_d      = ~owner_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      data_q      <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboarded bench for logic_unit_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_logic_unit_arbiter;

  localparam int unsigned WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]       exp_valid_q[$];
  logic [WIDTH-1:0] exp_data_q[$];

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] v, input logic [WIDTH-1:0] d);
    exp_valid_q.push_back(v);
    exp_data_q.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int idx, input logic [1:0] op,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[idx*2 +: 2]      = op;
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_ready"}, 64'(req_ready), 64'h0);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'h0);
    chk({tag, " rsp_data"},  64'(rsp_data),  64'h0);
    chk({tag, " busy"},      64'(busy),      64'h0);
  endtask

  // Full single-requester transaction with rsp_ready high; operands scrambled after accept.
  task automatic do_op(input int idx, input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    logic [1:0] onehot;
    onehot    = (idx == 1) ? 2'b10 : 2'b01;
    set_slot(idx, op, a, b);
    req_valid = onehot;
    rsp_ready = 2'b11;
    #1;
    chk("op req_ready", 64'(req_ready), 64'(onehot));
    push(onehot, exp);
    step();
    req_valid = 2'b00;
    set_slot(idx, ~op, ~a, b ^ 32'h5A5A_5A5A);
    step();
    chk("op rsp_valid latency", 64'(rsp_valid), 64'(onehot));
    step();
    chk("op busy after rsp", 64'(busy), 64'h0);
  endtask

  // Monitor: compare on each response handshake.
  always @(negedge clk) begin
    if ((rsp_valid & rsp_ready) != 2'b00) begin
      if (exp_valid_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected rsp: got valid=%b data=%h want none", rsp_valid, rsp_data);
      end else begin
        logic [1:0]       ev;
        logic [WIDTH-1:0] ed;
        ev = exp_valid_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("rsp {valid,data}", 64'({rsp_valid, rsp_data}), 64'({ev, ed}));
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = 2'b00;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Req 0 AND, then req 1 OR/XOR/NOR.
    do_op(0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    chk("rsp_data held after handshake", 64'(rsp_data), 64'hF000_F000);
    do_op(1, 2'b01, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F);
    do_op(1, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977);
    do_op(1, 2'b11, 32'h1234_5678, 32'h0F0F_0F0F, 32'hE0C0_A080);

    // Both continuously valid: grants alternate 0,1,0,1 every 3 cycles.
    set_slot(0, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00);
    set_slot(1, 2'b10, 32'h1234_5678, 32'h0F0F_0F0F);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) push((i % 2) ? 2'b10 : 2'b01,
                                     (i % 2) ? 32'h1D3B_5977 : 32'hF000_F000);
    for (int i = 0; i < 12; i++) begin
      logic [1:0] er;
      er = (i % 3 != 0) ? 2'b00 : (((i / 3) % 2) ? 2'b10 : 2'b01);
      #1;
      chk($sformatf("alt req_ready c%0d", i), 64'(req_ready), 64'(er));
      step();
    end
    req_valid = 2'b00;

    // Response stall: owner not ready, inputs churn, result must hold.
    set_slot(0, 2'b11, 32'h0000_FFFF, 32'h00FF_00FF);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    chk("stall req_ready", 64'(req_ready), 64'h1);
    push(2'b01, 32'hFF00_0000);
    step();
    req_valid = 2'b00;
    step();
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b11;
      req_op    = 4'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      rsp_ready = 2'b10;
      #1;
      chk("stall rsp_valid", 64'(rsp_valid), 64'h1);
      chk("stall rsp_data",  64'(rsp_data),  64'hFF00_0000);
      chk("stall busy",      64'(busy),      64'h1);
      chk("stall req_ready", 64'(req_ready), 64'h0);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    chk("stall done busy", 64'(busy), 64'h0);

    // Reset during EXEC (prio is 1 here; reset must bring it back to 0).
    set_slot(1, 2'b00, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    req_valid = 2'b10;
    #1;
    chk("exec-rst req_ready", 64'(req_ready), 64'h2);
    step();
    chk("exec-rst busy", 64'(busy), 64'h1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk_reset("exec-rst");
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("exec-rst no rsp", 64'(rsp_valid), 64'h0);
    req_valid = 2'b11;
    #1;
    chk("exec-rst next grant", 64'(req_ready), 64'h1);
    req_valid = 2'b00;
    step();

    // Reset during RESP (set prio to 1 first).
    do_op(0, 2'b01, 32'h0000_0001, 32'h8000_0000, 32'h8000_0001);
    set_slot(1, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    #1;
    chk("resp-rst req_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b00;
    step();
    chk("resp-rst rsp_valid", 64'(rsp_valid), 64'h2);
    rst_n = 1'b0;
    #1;
    chk_reset("resp-rst");
    rsp_ready = 2'b11;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("resp-rst no rsp", 64'(rsp_valid), 64'h0);
    req_valid = 2'b11;
    #1;
    chk("resp-rst next grant", 64'(req_ready), 64'h1);
    req_valid = 2'b00;

    repeat (3) step();
    chk("scoreboard drained", 64'(exp_valid_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
